// File: rtl/twi_mirror_regbank.sv
// Mirror register bank shared by the host bus and the I2C slave's Wishbone master.
// It adds per-side write masks, TWI byte-lane writes, dirty tracking and a dirty interrupt.
module twi_mirror_regbank #(
    parameter int                    ADDR_WIDTH    = 4,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    NUM_REGS      = 8,
    parameter int                    WB_ADDR_WIDTH = 32,
    parameter logic [NUM_REGS-1:0]   HOST_WR_MASK  = {NUM_REGS{1'b1}},
    parameter logic [NUM_REGS-1:0]   TWI_WR_MASK   = {NUM_REGS{1'b1}},
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wren_i,
    input  logic                     rden_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     ack_o,
    output logic                     irq_o,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0]    wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]  wb_sel_i,
    output logic [DATA_WIDTH-1:0]    wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int WB_IDX_W  = WB_ADDR_WIDTH - 2;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 dirty_q, dirty_d;
    logic [NUM_REGS-1:0]                 irq_en_q, irq_en_d;
    logic                                irq_q;
    logic                                ack_q;
    logic [DATA_WIDTH-1:0]               data_q;
    logic                                wb_ack_q, wb_err_q, wb_busy_q;
    logic [DATA_WIDTH-1:0]               wb_dat_q;

    // Host side decode
    logic                  host_acc, host_dirty_wr, host_en_wr;
    logic [NUM_REGS-1:0]   host_sel;
    logic [DATA_WIDTH-1:0] host_rdata;

    assign host_acc      = wren_i | rden_i;
    assign host_dirty_wr = wren_i && (addr_i == ADDR_WIDTH'(0));
    assign host_en_wr    = wren_i && (addr_i == ADDR_WIDTH'(1));
    assign irq_en_d      = host_en_wr ? data_i[NUM_REGS-1:0] : irq_en_q;

    always_comb begin
        host_rdata = '0;
        if (addr_i == ADDR_WIDTH'(0)) begin
            host_rdata[NUM_REGS-1:0] = dirty_q;
        end else if (addr_i == ADDR_WIDTH'(1)) begin
            host_rdata[NUM_REGS-1:0] = irq_en_q;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (host_sel[i]) begin
                host_rdata = regs_q[i];
            end
        end
    end

    // Wishbone side decode; byte offset bits are not part of the word index
    logic [WB_IDX_W-1:0]   wb_idx;
    logic [NUM_REGS-1:0]   wb_hit;
    logic                  wb_strobe, wb_req, wb_idx_ok, wb_perm, wb_bad;
    logic                  wb_wr_ok, wb_rd_ok;
    logic [DATA_WIDTH-1:0] wb_rdata;
    logic                  wb_adr_unused;

    assign wb_idx        = wb_adr_i[WB_ADDR_WIDTH-1:2];
    assign wb_adr_unused = ^wb_adr_i[1:0];
    assign wb_strobe     = wb_cyc_i & wb_stb_i;
    // wb_busy_q blocks a strobe that stays high after being served
    assign wb_req        = wb_strobe & ~wb_busy_q & ~wb_ack_q & ~wb_err_q;
    assign wb_idx_ok     = |wb_hit;
    assign wb_perm       = |(wb_hit & TWI_WR_MASK);
    assign wb_bad        = ~wb_idx_ok | (wb_we_i & ~wb_perm);
    assign wb_wr_ok      = wb_req & wb_we_i & ~wb_bad;
    assign wb_rd_ok      = wb_req & ~wb_we_i & ~wb_bad;

    always_comb begin
        wb_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_hit[i]) begin
                wb_rdata = regs_q[i];
            end
        end
    end

    genvar gi, gl;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic host_wr, twi_wr;

            assign host_sel[gi] = (addr_i == ADDR_WIDTH'(gi + 2));
            assign wb_hit[gi]   = (wb_idx == WB_IDX_W'(gi));
            assign host_wr      = wren_i & host_sel[gi] & HOST_WR_MASK[gi];
            assign twi_wr       = wb_wr_ok & wb_hit[gi];
            // A TWI update outranks a host clear of the same dirty bit
            assign dirty_d[gi]  = twi_wr | (dirty_q[gi] & ~(host_dirty_wr & data_i[gi]));

            for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
                assign regs_d[gi][gl*8 +: 8] =
                    (twi_wr && wb_sel_i[gl]) ? wb_dat_i[gl*8 +: 8] :
                    host_wr                  ? data_i[gl*8 +: 8]   :
                                               regs_q[gi][gl*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q    <= {NUM_REGS{RESET_VALUE}};
            dirty_q   <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            wb_ack_q  <= 1'b0;
            wb_err_q  <= 1'b0;
            wb_busy_q <= 1'b0;
            wb_dat_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            dirty_q   <= dirty_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= |(dirty_q & irq_en_q);
            ack_q     <= host_acc;
            data_q    <= host_acc ? host_rdata : '0;
            wb_ack_q  <= wb_req & ~wb_bad;
            wb_err_q  <= wb_req & wb_bad;
            wb_busy_q <= wb_strobe;
            wb_dat_q  <= wb_rd_ok ? wb_rdata : '0;
        end
    end

    assign data_o   = data_q;
    assign ack_o    = ack_q;
    assign irq_o    = irq_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_ack_o = wb_ack_q;
    assign wb_err_o = wb_err_q;

endmodule

// File: tb/tb_twi_mirror_regbank.sv
// Bench for twi_mirror_regbank: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_twi_mirror_regbank;
    localparam int         NR    = 8;
    localparam logic [7:0] HMASK = 8'h0F;
    localparam logic [7:0] TMASK = 8'hFE;

    logic        clk = 1'b0;
    logic        rst, wren, rden, ack, irq;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic [3:0]  wb_sel;

    always #5 clk = ~clk;

    twi_mirror_regbank #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(NR), .WB_ADDR_WIDTH(32),
        .HOST_WR_MASK(HMASK), .TWI_WR_MASK(TMASK), .RESET_VALUE(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wren_i(wren), .rden_i(rden), .addr_i(addr),
        .data_i(wdata), .data_o(rdata), .ack_o(ack), .irq_o(irq),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_wdat), .wb_sel_i(wb_sel), .wb_dat_o(wb_rdat),
        .wb_ack_o(wb_ack), .wb_err_o(wb_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state and the outputs expected after the next clock edge
    logic [31:0] m_reg [NR];
    logic [7:0]  m_dirty, m_en;
    logic        m_prev_stb;
    logic        e_ack, e_irq, e_wack, e_werr;
    logic [31:0] e_data, e_wdat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int          a, idx;
        logic        newreq, bad;
        logic [31:0] hv;
        logic [31:0] nreg [NR];
        logic [7:0]  nd;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_reg[i] = 32'h0;
            m_dirty = 8'h0; m_en = 8'h0; m_prev_stb = 1'b0;
            e_ack = 1'b0; e_data = 32'h0; e_irq = 1'b0;
            e_wack = 1'b0; e_werr = 1'b0; e_wdat = 32'h0;
            return;
        end
        a = int'(addr);
        e_irq = |(m_dirty & m_en);
        hv = 32'h0;
        if (a == 0)           hv = {24'h0, m_dirty};
        else if (a == 1)      hv = {24'h0, m_en};
        else if (a < NR + 2)  hv = m_reg[a-2];
        e_ack  = wren | rden;
        e_data = e_ack ? hv : 32'h0;

        idx    = int'(wb_adr >> 2);
        newreq = wb_cyc && wb_stb && !m_prev_stb && !e_wack && !e_werr;
        bad    = (idx >= NR) || (wb_we && !TMASK[idx]);
        e_wack = newreq && !bad;
        e_werr = newreq && bad;
        e_wdat = (e_wack && !wb_we) ? m_reg[idx] : 32'h0;

        for (int i = 0; i < NR; i++) nreg[i] = m_reg[i];
        nd = m_dirty;
        if (wren && a >= 2 && a < NR + 2 && HMASK[a-2]) nreg[a-2] = wdata;
        if (wren && a == 0) nd = nd & ~wdata[7:0];
        if (wren && a == 1) m_en = wdata[7:0];
        if (e_wack && wb_we) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) nreg[idx][8*b +: 8] = wb_wdat[8*b +: 8];
            nd[idx] = 1'b1;
        end
        for (int i = 0; i < NR; i++) m_reg[i] = nreg[i];
        m_dirty    = nd;
        m_prev_stb = wb_cyc && wb_stb;
    endtask

    task automatic check_outputs();
        chk("ack_o",    {31'h0, ack},    {31'h0, e_ack});
        chk("data_o",   rdata,           e_data);
        chk("irq_o",    {31'h0, irq},    {31'h0, e_irq});
        chk("wb_ack_o", {31'h0, wb_ack}, {31'h0, e_wack});
        chk("wb_err_o", {31'h0, wb_err}, {31'h0, e_werr});
        chk("wb_dat_o", wb_rdat,         e_wdat);
    endtask

    // Inputs are already driven; advance one clock and compare against the model
    task automatic tick();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        wren = 1'b1; addr = a; wdata = d;
        tick();
        wren = 1'b0;
        chk("host_wr_ack", {31'h0, ack}, 32'h1);
        $display("host write addr=%0d data=%h", a, d);
    endtask

    task automatic host_read(input logic [3:0] a, output logic [31:0] d);
        rden = 1'b1; addr = a;
        tick();
        rden = 1'b0;
        chk("host_rd_ack", {31'h0, ack}, 32'h1);
        d = rdata;
        $display("host read  addr=%0d data=%h", a, d);
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] d,
                             input logic [3:0] sel, output logic ack_s, output logic err_s,
                             output logic [31:0] dat_s);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = d; wb_sel = sel;
        tick();
        ack_s = wb_ack; err_s = wb_err; dat_s = wb_rdat;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        $display("wb %s adr=%h data=%h sel=%b ack=%0d err=%0d rdat=%h",
                 we ? "write" : "read ", adr, d, sel, ack_s, err_s, dat_s);
    endtask

    initial begin
        logic [31:0] v, d_s;
        logic        a_s, e_s;
        int          count;

        rst = 1'b1; wren = 1'b0; rden = 1'b0; addr = 4'h0; wdata = 32'h0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 32'h0;
        wb_wdat = 32'h0; wb_sel = 4'h0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_ack", {31'h0, ack}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        for (int a = 2; a < NR + 2; a++) begin
            host_read(4'(a), v);
            chk("reset_reg", v, 32'h0);
        end
        host_read(4'd0, v);
        chk("reset_dirty", v, 32'h0);

        // Dirty flag and interrupt on register 1 (register 0 is TWI read-only here)
        host_write(4'd1, 32'h0000_0002);
        wb_access(1'b1, 32'h04, 32'hA5A5A5A5, 4'b0011, a_s, e_s, d_s);
        chk("wb_wr_ack", {31'h0, a_s}, 32'h1);
        chk("wb_wr_err", {31'h0, e_s}, 32'h0);
        chk("irq_set", {31'h0, irq}, 32'h1);
        host_read(4'd3, v);
        chk("reg1_lanes", v, 32'h0000A5A5);
        host_read(4'd0, v);
        chk("dirty_after_wb", v, 32'h02);
        host_write(4'd0, 32'h0000_0002);
        host_read(4'd0, v);
        chk("dirty_cleared", v, 32'h0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Write masks and out-of-range index
        wb_access(1'b1, 32'h00, 32'hDEADBEEF, 4'hF, a_s, e_s, d_s);
        chk("twi_mask_err", {31'h0, e_s}, 32'h1);
        chk("twi_mask_noack", {31'h0, a_s}, 32'h0);
        wb_access(1'b0, 32'h00, 32'h0, 4'h0, a_s, e_s, d_s);
        chk("twi_mask_unchanged", d_s, 32'h0);
        wb_access(1'b0, 32'h20, 32'h0, 4'h0, a_s, e_s, d_s);
        chk("wb_range_err", {31'h0, e_s}, 32'h1);
        chk("wb_range_dat", d_s, 32'h0);
        host_write(4'd7, 32'h12345678);
        host_read(4'd7, v);
        chk("host_mask_blocked", v, 32'h0);
        host_write(4'd2, 32'h12345678);
        wb_access(1'b0, 32'h02, 32'h0, 4'h0, a_s, e_s, d_s);
        chk("host_wr_seen_by_wb", d_s, 32'h12345678);

        // Same-cycle host and TWI write to register 1
        wren = 1'b1; addr = 4'd3; wdata = 32'h11111111;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h04;
        wb_wdat = 32'hFFFFFFFF; wb_sel = 4'b1000;
        tick();
        wren = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        $display("collision write reg1 host=11111111 twi=FFFFFFFF sel=1000");
        host_read(4'd3, v);
        chk("collision_merge", v, 32'hFF111111);
        host_read(4'd0, v);
        chk("collision_dirty", v, 32'h02);

        // Same-cycle dirty set (sel=0) and host clear of that bit
        wren = 1'b1; addr = 4'd0; wdata = 32'h02;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h04;
        wb_wdat = 32'h0; wb_sel = 4'b0000;
        tick();
        wren = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        $display("dirty set vs host clear on bit 1");
        host_read(4'd0, v);
        chk("set_beats_clear", v, 32'h02);
        host_read(4'd3, v);
        chk("sel0_no_data", v, 32'hFF111111);

        // Strobe held for four cycles is served once
        count = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_ack) count++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
        if (wb_ack) count++;
        $display("held strobe produced %0d acks", count);
        chk("held_stb_acks", 32'(count), 32'h1);

        // Reset while a host ack is outstanding
        rden = 1'b1; addr = 4'd3;
        tick();
        rden = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drops_ack", {31'h0, ack}, 32'h0);
        chk("rst_data_zero", rdata, 32'h0);
        host_read(4'd3, v);
        chk("rst_reg", v, 32'h0);
        host_read(4'd1, v);
        chk("rst_irq_en", v, 32'h0);
        host_read(4'd0, v);
        chk("rst_dirty", v, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wren    = ($urandom_range(0, 3) == 0);
            rden    = ($urandom_range(0, 3) == 0);
            addr    = 4'($urandom_range(0, 15));
            wdata   = $urandom();
            wb_cyc  = ($urandom_range(0, 3) != 0);
            wb_stb  = ($urandom_range(0, 1) == 0);
            wb_we   = ($urandom_range(0, 1) == 0);
            wb_adr  = 32'($urandom_range(0, 47));
            wb_wdat = $urandom();
            wb_sel  = 4'($urandom_range(0, 15));
            tick();
        end
        $display("random phase complete: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
